// File: rtl/iommu_fq_writer.sv
// Fault-queue writer: buffers fault records and writes each one into the memory queue as four 64-bit beats.
// Define IOMMU_FQ_DROP_CNT_EN to add the saturating drop_cnt_o counter.
package iommu_pkg;
    typedef struct packed {
        logic [63:0] iotval2;
        logic [63:0] iotval;
        logic [31:0] rsvd;
        logic [31:0] custom;
        logic [23:0] did;
        logic [5:0]  ttyp;
        logic        priv;
        logic        pv;
        logic [19:0] pid;
        logic [11:0] cause;
    } fq_record_t;
endpackage

module iommu_fq_writer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 56
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ev_valid_i,
    output logic                  ev_ready_o,
    input  iommu_pkg::fq_record_t ev_record_i,
    input  logic [43:0]           fqb_ppn_i,
    input  logic [4:0]            fqb_log2szm1_i,
    input  logic [31:0]           fqh_i,
    output logic [31:0]           fqt_o,
    input  logic                  fqen_i,
    output logic                  fqon_o,
    output logic                  busy_o,
    output logic                  fqmf_o,
    output logic                  fqof_o,
    input  logic                  fqmf_clr_i,
    input  logic                  fqof_clr_i,
    output logic                  fip_o,
    input  logic                  fip_clr_i,
    output logic                  mem_req_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [63:0]           mem_data_o,
    output logic                  mem_last_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_resp_i,
    input  logic                  mem_err_i
`ifdef IOMMU_FQ_DROP_CNT_EN
    ,
    output logic [15:0]           drop_cnt_o
`endif
);
    import iommu_pkg::*;

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, CHECK, BEAT, RESP} state_e;

    state_e              state_q, state_d;
    logic [1:0]          beat_q, beat_d;
    logic [31:0]         fqt_q, fqt_d;
    logic                fqon_q, fqon_d;
    logic                fqen_q;
    logic                busy_q, busy_d;
    logic                fqmf_q, fqmf_d;
    logic                fqof_q, fqof_d;
    logic                fip_q, fip_d;
    logic                ev_ready_q, ev_ready_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [63:0]         mem_data_q, mem_data_d;
    logic                mem_last_q, mem_last_d;

    fq_record_t          fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [31:0]         mask;
    logic [63:0]         addr_full;
    logic [255:0]        head_bits;
    logic                fifo_empty, push_hs, push_store, en_rise;
    logic                pop, flush, mf_set, of_set, fip_set;

    // Queue index mask is 2^(log2szm1+1)-1; the extra bit keeps log2szm1=31 from overflowing.
    assign mask       = 32'((33'd1 << (6'(fqb_log2szm1_i) + 6'd1)) - 33'd1);
    assign fifo_empty = (cnt_q == '0);
    assign push_hs    = ev_valid_i && ev_ready_q;
    assign push_store = push_hs && fqon_q;
    assign en_rise    = fqen_i && !fqen_q;
    assign head_bits  = fifo_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        fqt_d   = fqt_q & mask;
        fqon_d  = fqon_q;
        pop     = 1'b0;
        flush   = 1'b0;
        mf_set  = 1'b0;
        of_set  = 1'b0;
        fip_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (fqon_q && fqen_i && !fifo_empty) state_d = CHECK;
            end
            CHECK: begin
                if (fifo_empty) begin
                    state_d = IDLE;
                end else if (fqmf_q || fqof_q) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end else if (((fqt_q + 32'd1) & mask) == (fqh_i & mask)) begin
                    of_set  = 1'b1;
                    pop     = 1'b1;
                    state_d = IDLE;
                end else begin
                    beat_d  = 2'd0;
                    state_d = BEAT;
                end
            end
            BEAT: begin
                if (mem_gnt_i) begin
                    if (beat_q == 2'd3) state_d = RESP;
                    else                beat_d  = beat_q + 2'd1;
                end
            end
            RESP: begin
                if (mem_resp_i) begin
                    pop     = !fifo_empty;
                    state_d = IDLE;
                    if (mem_err_i) begin
                        mf_set = 1'b1;
                    end else begin
                        fqt_d   = (fqt_q + 32'd1) & mask;
                        fip_set = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable only completes once no write is in flight.
        if (fqon_q && !fqen_i && state_q == IDLE) begin
            fqon_d = 1'b0;
            flush  = 1'b1;
        end
        if (en_rise) begin
            fqon_d = 1'b1;
            fqt_d  = '0;
            flush  = 1'b1;
        end

        busy_d = (state_d != IDLE) || (fqon_d && !fqen_i);

        // Sticky bits: set beats a same-cycle clear; the enable edge clears fqmf/fqof.
        fqmf_d = fqmf_q;
        if (fqmf_clr_i) fqmf_d = 1'b0;
        if (mf_set)     fqmf_d = 1'b1;
        if (en_rise)    fqmf_d = 1'b0;
        fqof_d = fqof_q;
        if (fqof_clr_i) fqof_d = 1'b0;
        if (of_set)     fqof_d = 1'b1;
        if (en_rise)    fqof_d = 1'b0;
        fip_d = fip_q;
        if (fip_clr_i)  fip_d = 1'b0;
        if (fip_set)    fip_d = 1'b1;

        wr_ptr_d = push_store ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push_store) - CNT_W'(pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
        ev_ready_d = (cnt_d != CNT_W'(FIFO_DEPTH));

        addr_full  = 64'({fqb_ppn_i, 12'h000}) + (64'(fqt_q) << 5) + (64'(beat_d) << 3);
        mem_req_d  = (state_d == BEAT);
        mem_last_d = (state_d == BEAT) && (beat_d == 2'd3);
        mem_addr_d = (state_d == BEAT) ? ADDR_W'(addr_full) : '0;
        mem_data_d = (state_d == BEAT) ? head_bits[{beat_d, 6'd0} +: 64] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            fqt_q      <= '0;
            fqon_q     <= 1'b0;
            fqen_q     <= 1'b0;
            busy_q     <= 1'b0;
            fqmf_q     <= 1'b0;
            fqof_q     <= 1'b0;
            fip_q      <= 1'b0;
            ev_ready_q <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_last_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            fqt_q      <= fqt_d;
            fqon_q     <= fqon_d;
            fqen_q     <= fqen_i;
            busy_q     <= busy_d;
            fqmf_q     <= fqmf_d;
            fqof_q     <= fqof_d;
            fip_q      <= fip_d;
            ev_ready_q <= ev_ready_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_last_q <= mem_last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Record storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push_store) fifo_q[wr_ptr_q] <= ev_record_i;
    end

`ifdef IOMMU_FQ_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum;

    // Drops: pushes while off, plus records discarded in CHECK.
    always_comb begin
        drop_sum   = 17'(drop_cnt_q) + 17'(push_hs && !fqon_q) + 17'((state_q == CHECK) && pop);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (en_rise) drop_cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

    assign ev_ready_o = ev_ready_q;
    assign fqt_o      = fqt_q;
    assign fqon_o     = fqon_q;
    assign busy_o     = busy_q;
    assign fqmf_o     = fqmf_q;
    assign fqof_o     = fqof_q;
    assign fip_o      = fip_q;
    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign mem_last_o = mem_last_q;

endmodule

// File: tb/tb_iommu_fq_writer.sv
// Directed bench for iommu_fq_writer: write path, overflow, memory fault, wrap/backpressure, disable and reset.
module tb_iommu_fq_writer;
    import iommu_pkg::*;

    localparam int unsigned ADDR_W = 56;
    localparam logic [63:0] BASE   = 64'h8000_0000;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              ev_valid_i = 1'b0;
    logic              ev_ready_o;
    fq_record_t        ev_record_i = '0;
    logic [43:0]       fqb_ppn_i = 44'h80000;
    logic [4:0]        fqb_log2szm1_i = 5'd3;
    logic [31:0]       fqh_i = '0;
    logic [31:0]       fqt_o;
    logic              fqen_i = 1'b0;
    logic              fqon_o, busy_o, fqmf_o, fqof_o, fip_o;
    logic              fqmf_clr_i = 1'b0, fqof_clr_i = 1'b0, fip_clr_i = 1'b0;
    logic              mem_req_o, mem_last_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [63:0]       mem_data_o;
    logic              mem_gnt_i = 1'b1, mem_resp_i = 1'b1, mem_err_i = 1'b0;
`ifdef IOMMU_FQ_DROP_CNT_EN
    logic [15:0]       drop_cnt_o;
`endif

    int vectors = 0;
    int errors  = 0;

    iommu_fq_writer #(.FIFO_DEPTH(4), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ev_valid_i(ev_valid_i), .ev_ready_o(ev_ready_o), .ev_record_i(ev_record_i),
        .fqb_ppn_i(fqb_ppn_i), .fqb_log2szm1_i(fqb_log2szm1_i), .fqh_i(fqh_i), .fqt_o(fqt_o),
        .fqen_i(fqen_i), .fqon_o(fqon_o), .busy_o(busy_o), .fqmf_o(fqmf_o), .fqof_o(fqof_o),
        .fqmf_clr_i(fqmf_clr_i), .fqof_clr_i(fqof_clr_i), .fip_o(fip_o), .fip_clr_i(fip_clr_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_last_o(mem_last_o), .mem_gnt_i(mem_gnt_i), .mem_resp_i(mem_resp_i), .mem_err_i(mem_err_i)
`ifdef IOMMU_FQ_DROP_CNT_EN
        , .drop_cnt_o(drop_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic fq_record_t mk(input logic [11:0] cause, input logic [23:0] did, input logic [63:0] tv);
        fq_record_t r;
        r.cause   = cause;
        r.pid     = 20'd5;
        r.pv      = 1'b1;
        r.priv    = 1'b0;
        r.ttyp    = 6'd1;
        r.did     = did;
        r.custom  = 32'hC0DE_0000 | 32'(did);
        r.rsvd    = '0;
        r.iotval  = tv;
        r.iotval2 = ~tv;
        return r;
    endfunction

    task automatic push(input fq_record_t r);
        int n;
        n = 0;
        while (!ev_ready_o && n < 8) begin step(); n++; end
        chk("push ready", 64'(ev_ready_o), 64'd1);
        ev_record_i = r;
        ev_valid_i  = 1'b1;
        step();
        ev_valid_i  = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!mem_req_o && n < 12) begin step(); n++; end
        chk({tag, " req"}, 64'(mem_req_o), 64'd1);
    endtask

    // Follows one four-beat write; stall_beat >= 0 holds mem_gnt_i low for stall_n cycles on that beat.
    task automatic expect_write(input string tag, input logic [63:0] addr0, input fq_record_t rec,
                                input int stall_beat, input int stall_n, output logic [63:0] beat0);
        logic [255:0] bits;
        bits  = rec;
        beat0 = '0;
        wait_req(tag);
        if (!mem_req_o) return;
        beat0 = mem_data_o;
        for (int b = 0; b < 4; b++) begin
            if (b == stall_beat) begin
                mem_gnt_i = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    step();
                    chk({tag, " stall addr"}, 64'(mem_addr_o), addr0 + 64'(b * 8));
                    chk({tag, " stall data"}, mem_data_o, bits[b*64 +: 64]);
                end
                mem_gnt_i = 1'b1;
            end
            chk({tag, " addr"}, 64'(mem_addr_o), addr0 + 64'(b * 8));
            chk({tag, " data"}, mem_data_o, bits[b*64 +: 64]);
            chk({tag, " last"}, 64'(mem_last_o), 64'(b == 3));
            step();
        end
        chk({tag, " req after last"}, 64'(mem_req_o), 64'd0);
        step();
    endtask

    task automatic expect_no_req(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            if (mem_req_o) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [63:0] b0;
        int          n;

        // Reset
        step();
        step();
        chk("rst ready", 64'(ev_ready_o), 64'd0);
        chk("rst fqt", 64'(fqt_o), 64'd0);
        chk("rst fqon", 64'(fqon_o), 64'd0);
        chk("rst busy", 64'(busy_o), 64'd0);
        chk("rst flags", {61'd0, fqmf_o, fqof_o, fip_o}, 64'd0);
        chk("rst req", 64'(mem_req_o), 64'd0);
        rst_i = 1'b0;
        step();

        // Basic write
        fqen_i = 1'b1;
        step();
        chk("enable fqon", 64'(fqon_o), 64'd1);
        push(mk(12'd257, 24'h12, 64'h0000_0000_dead_1000));
        expect_write("basic", BASE, mk(12'd257, 24'h12, 64'h0000_0000_dead_1000), -1, 0, b0);
        chk("basic beat0", b0, 64'h0000_1205_0000_5101);
        chk("basic cause", 64'(b0[11:0]), 64'd257);
        chk("basic fqt", 64'(fqt_o), 64'd1);
        chk("basic fip", 64'(fip_o), 64'd1);
        fip_clr_i = 1'b1;
        step();
        fip_clr_i = 1'b0;
        chk("fip clear", 64'(fip_o), 64'd0);

        // Full / overflow with a two-entry queue
        fqen_i = 1'b0;
        step();
        step();
        chk("disable fqon", 64'(fqon_o), 64'd0);
        fqb_log2szm1_i = 5'd0;
        fqh_i  = 32'd0;
        fqen_i = 1'b1;
        step();
        chk("reenable fqt", 64'(fqt_o), 64'd0);
        push(mk(12'd1, 24'h1, 64'h1111));
        push(mk(12'd2, 24'h2, 64'h2222));
        push(mk(12'd3, 24'h3, 64'h3333));
        expect_write("ovf first", BASE, mk(12'd1, 24'h1, 64'h1111), -1, 0, b0);
        expect_no_req("ovf dropped no req", 14);
        chk("ovf fqof", 64'(fqof_o), 64'd1);
        chk("ovf fqt", 64'(fqt_o), 64'd1);
        fqh_i      = 32'd1;
        fqof_clr_i = 1'b1;
        step();
        fqof_clr_i = 1'b0;
        chk("fqof clear", 64'(fqof_o), 64'd0);
        push(mk(12'd4, 24'h4, 64'h4444));
        expect_write("ovf after clr", BASE + 64'h20, mk(12'd4, 24'h4, 64'h4444), -1, 0, b0);
        chk("ovf wrap fqt", 64'(fqt_o), 64'd0);

        // Memory fault
        fqb_log2szm1_i = 5'd3;
        fqh_i     = 32'd0;
        mem_err_i = 1'b1;
        push(mk(12'd5, 24'h5, 64'h5555));
        expect_write("mf write", BASE, mk(12'd5, 24'h5, 64'h5555), -1, 0, b0);
        mem_err_i = 1'b0;
        chk("mf fqmf", 64'(fqmf_o), 64'd1);
        chk("mf fqt", 64'(fqt_o), 64'd0);
        push(mk(12'd6, 24'h6, 64'h6666));
        push(mk(12'd7, 24'h7, 64'h7777));
        expect_no_req("mf blocked no req", 14);
        chk("mf still set", 64'(fqmf_o), 64'd1);
        fqmf_clr_i = 1'b1;
        step();
        fqmf_clr_i = 1'b0;
        chk("fqmf clear", 64'(fqmf_o), 64'd0);
        fip_clr_i = 1'b1;
        push(mk(12'd8, 24'h8, 64'h8888));
        expect_write("mf retry", BASE, mk(12'd8, 24'h8, 64'h8888), -1, 0, b0);
        chk("fip set beats clear", 64'(fip_o), 64'd1);
        step();
        chk("fip clear after", 64'(fip_o), 64'd0);
        fip_clr_i = 1'b0;
        chk("mf retry fqt", 64'(fqt_o), 64'd1);

        // Wrap and backpressure with a four-entry queue
        fqb_log2szm1_i = 5'd1;
        fqh_i = 32'd1;
        push(mk(12'd9, 24'h9, 64'h9999));
        expect_write("wrap g", BASE + 64'h20, mk(12'd9, 24'h9, 64'h9999), -1, 0, b0);
        push(mk(12'd10, 24'hA, 64'hAAAA));
        expect_write("wrap h", BASE + 64'h40, mk(12'd10, 24'hA, 64'hAAAA), -1, 0, b0);
        chk("wrap pre fqt", 64'(fqt_o), 64'd3);
        fqh_i = 32'd3;
        push(mk(12'd11, 24'hB, 64'hBBBB));
        expect_write("wrap i", BASE + 64'h60, mk(12'd11, 24'hB, 64'hBBBB), 2, 5, b0);
        chk("wrap fqt", 64'(fqt_o), 64'd0);

        // Disable mid-burst
        push(mk(12'd12, 24'hC, 64'hCCCC));
        wait_req("dis");
        fqen_i = 1'b0;
        step();
        chk("dis busy", 64'(busy_o), 64'd1);
        chk("dis fqon held", 64'(fqon_o), 64'd1);
        n = 0;
        while (fqon_o && n < 16) begin step(); n++; end
        chk("dis fqon off", 64'(fqon_o), 64'd0);
        chk("dis busy off", 64'(busy_o), 64'd0);
        chk("dis fqt", 64'(fqt_o), 64'd1);
        push(mk(12'd13, 24'hD, 64'hDDDD));
        expect_no_req("off drop no req", 10);

        // Reset mid-burst
        fqen_i = 1'b1;
        step();
        chk("re-en fqt", 64'(fqt_o), 64'd0);
        push(mk(12'd14, 24'hE, 64'hEEEE));
        expect_write("rst pre", BASE, mk(12'd14, 24'hE, 64'hEEEE), -1, 0, b0);
        push(mk(12'd15, 24'hF, 64'hFFFF));
        wait_req("rst burst");
        step();
        chk("rst burst beat1 addr", 64'(mem_addr_o), BASE + 64'h28);
        rst_i  = 1'b1;
        fqen_i = 1'b0;
        step();
        chk("rst mid req", 64'(mem_req_o), 64'd0);
        chk("rst mid fqt", 64'(fqt_o), 64'd0);
        chk("rst mid fqon", 64'(fqon_o), 64'd0);
        rst_i = 1'b0;
        step();

`ifdef IOMMU_FQ_DROP_CNT_EN
        for (int i = 0; i < 5; i++) push(mk(12'(i), 24'h0, 64'h0));
        chk("drop cnt", 64'(drop_cnt_o), 64'd5);
        fqen_i = 1'b1;
        step();
        chk("drop cnt clear", 64'(drop_cnt_o), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
